// File: rtl/chaotic_map_bank_if.sv
// Control and stream bundle for chaotic_map_bank: run/seed controls in,
// per-update output stream and sticky fixed-point flags out.
interface chaotic_map_bank_if #(
  parameter int W  = 16,
  parameter int CH = 4
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  logic          i_en;
  logic [1:0]    i_mode;
  logic          i_seed_we;
  logic [CW-1:0] i_seed_ch;
  logic [W-1:0]  i_seed_data;
  logic          i_clear_stuck;
  logic          o_out_valid;
  logic [CW-1:0] o_out_ch;
  logic [W-1:0]  o_out_data;
  logic [CH-1:0] o_stuck;

  modport master (
    output i_en, i_mode, i_seed_we, i_seed_ch, i_seed_data, i_clear_stuck,
    input  o_out_valid, o_out_ch, o_out_data, o_stuck
  );

  modport slave (
    input  i_en, i_mode, i_seed_we, i_seed_ch, i_seed_data, i_clear_stuck,
    output o_out_valid, o_out_ch, o_out_data, o_stuck
  );
endinterface

// File: rtl/chaotic_map_bank.sv
// Multi-channel chaotic-map source: CH signed Q1.(W-1) states iterated round-robin
// through one shared signed multiplier (quadratic, tent or cubic Chebyshev map).
module chaotic_map_bank #(
  parameter int           W         = 16,
  parameter int           CH        = 4,
  parameter logic [W-1:0] SEED      = 16'h7EF0,
  parameter logic [W-1:0] SEED_STEP = 16'h0123,
  parameter logic [W-1:0] PERTURB   = 16'h0155
) (
  input  logic              clk,
  input  logic              rst,
  chaotic_map_bank_if.slave bus
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic signed [2*W-1:0] MAX_E = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] MIN_E = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0]  MAX_W   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MIN_W   = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] LAST_CH = CW'(CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL1, S_MUL2, S_WB} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_ptr;
  logic [1:0]            r_mode;
  logic                  r_discard;
  logic signed [2*W-1:0] r_prod;
  logic [W-1:0]          r_x [CH];
  logic                  r_out_valid;
  logic [CW-1:0]         r_out_ch;
  logic [W-1:0]          r_out_data;
  logic [CH-1:0]         r_stuck;

  logic signed [W-1:0]   w_x;
  logic signed [W-1:0]   w_s;
  logic signed [W-1:0]   w_mul_b;
  logic signed [2*W-1:0] w_xe;
  logic signed [2*W-1:0] w_be;
  logic signed [2*W-1:0] w_prod;
  logic signed [2*W-1:0] w_abs;
  logic signed [2*W-1:0] w_y;
  logic [W-1:0]          w_y_sat;
  logic [W-1:0]          w_store;
  logic                  w_fixed;
  logic                  w_seed_ok;
  logic                  w_seed_hit;
  logic                  w_commit;
  logic [CW-1:0]         w_ptr_next;

  function automatic logic [W-1:0] reset_seed(input int idx);
    return SEED + SEED_STEP * W'(idx);
  endfunction

  assign w_x = r_x[r_ptr];

  // Cubic map: s = min(MAX, floor(x*x / 2^(W-1))); x*x is never negative here.
  assign w_s = (r_prod[2*W-1:2*W-2] != 2'b00) ? MAX_W : r_prod[2*W-2:W-1];

  // Operands are sign-extended W-bit values, so this is one W x W signed multiply
  // shared between the x*x pass (MUL1) and the x*s pass (MUL2).
  assign w_mul_b = (r_state == S_MUL1) ? w_x : w_s;
  assign w_xe    = {{W{w_x[W-1]}}, w_x};
  assign w_be    = {{W{w_mul_b[W-1]}}, w_mul_b};
  assign w_prod  = w_xe * w_be;
  assign w_abs   = w_x[W-1] ? -w_xe : w_xe;

  // NOTE: give every always_comb output a default before the case, otherwise an
  // unlisted selector value keeps the old value and synthesis infers a latch.
  always_comb begin
    w_y = MAX_E - (r_prod >>> (W-2));
    case (r_mode)
      2'd1:    w_y = MAX_E - (w_abs <<< 1);
      2'd2:    w_y = ((r_prod >>> (W-1)) <<< 2) - (w_xe + (w_xe <<< 1));
      default: ;
    endcase
  end

  assign w_y_sat    = (w_y > MAX_E) ? MAX_W : (w_y < MIN_E) ? MIN_W : w_y[W-1:0];
  assign w_fixed    = (w_y_sat == r_x[r_ptr]);
  assign w_store    = w_fixed ? (w_y_sat ^ PERTURB) : w_y_sat;
  assign w_seed_ok  = (int'(bus.i_seed_ch) < CH);
  assign w_seed_hit = bus.i_seed_we && w_seed_ok && (bus.i_seed_ch == r_ptr);
  // A seed landing on the channel being written back overrides the computed value.
  assign w_commit   = (r_state == S_WB) && !r_discard && !w_seed_hit;
  assign w_ptr_next = (r_ptr == LAST_CH) ? '0 : r_ptr + 1'b1;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values and the later assignments below take priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_mode      <= 2'd0;
      r_discard   <= 1'b0;
      r_prod      <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_data  <= '0;
      r_stuck     <= '0;
      // NOTE: the state array is a small register file with defined reset seeds,
      // so it is reset explicitly rather than left to power-up contents.
      for (int i = 0; i < CH; i++) r_x[i] <= reset_seed(i);
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_en) begin
            r_mode    <= bus.i_mode;
            r_discard <= 1'b0;
            r_state   <= S_MUL1;
          end
        end
        S_MUL1: begin
          r_prod  <= w_prod;
          r_state <= (r_mode == 2'd2) ? S_MUL2 : S_WB;
        end
        S_MUL2: begin
          r_prod  <= w_prod;
          r_state <= S_WB;
        end
        S_WB: begin
          if (w_commit) begin
            r_x[r_ptr]  <= w_store;
            r_out_valid <= 1'b1;
            r_out_ch    <= r_ptr;
            r_out_data  <= w_store;
          end
          r_ptr     <= w_ptr_next;
          r_discard <= 1'b0;
          if (bus.i_en) begin
            r_mode  <= bus.i_mode;
            r_state <= S_MUL1;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase

      if (w_seed_hit && (r_state == S_MUL1 || r_state == S_MUL2)) r_discard <= 1'b1;
      if (bus.i_clear_stuck) r_stuck <= '0;
      if (w_commit && w_fixed) r_stuck[r_ptr] <= 1'b1;
      if (bus.i_seed_we && w_seed_ok) r_x[bus.i_seed_ch] <= bus.i_seed_data;
    end
  end

  assign bus.o_out_valid = r_out_valid;
  assign bus.o_out_ch    = r_out_ch;
  assign bus.o_out_data  = r_out_data;
  assign bus.o_stuck     = r_stuck;
endmodule

// File: tb/tb_chaotic_map_bank.sv
// Self-checking bench for chaotic_map_bank: randomized seeds/modes against a
// plain-arithmetic model of the three maps, plus directed timing and corner cases.
module tb_chaotic_map_bank;
  localparam int          W       = 16;
  localparam int          CH      = 4;
  localparam int          CW      = 2;
  localparam logic [15:0] PERTURB = 16'h0155;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chaotic_map_bank_if #(.W(W), .CH(CH)) bus ();

  chaotic_map_bank #(
    .W(W), .CH(CH), .SEED(16'h7EF0), .SEED_STEP(16'h0123), .PERTURB(16'h0155)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  longint        mx [CH];
  logic [CH-1:0] mstuck;
  int            mptr;

  int          got_ch[$];
  logic [15:0] got_data[$];
  int          gaps[$];

  function automatic longint to_signed(input logic [15:0] v);
    return (v >= 16'h8000) ? longint'(v) - 65536 : longint'(v);
  endfunction

  function automatic longint floor_div(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic longint map_next(input int mode, input longint x);
    longint y, s, c;
    case (mode)
      1: y = 32767 - 2 * ((x < 0) ? -x : x);
      2: begin
        s = floor_div(x * x, 32768);
        if (s > 32767) s = 32767;
        c = floor_div(x * s, 32768);
        y = 4 * c - 3 * x;
      end
      default: y = 32767 - floor_div(2 * x * x, 32768);
    endcase
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) mx[i] = to_signed(16'(32'h7EF0 + i * 32'h0123));
    mstuck = '0;
    mptr   = 0;
  endtask

  task automatic model_step(input int mode, output int ch, output logic [15:0] data);
    longint y;
    ch = mptr;
    y  = map_next(mode, mx[ch]);
    if (y == mx[ch]) begin
      data       = 16'(y) ^ PERTURB;
      mstuck[ch] = 1'b1;
    end else begin
      data = 16'(y);
    end
    mx[ch] = to_signed(data);
    mptr   = (mptr + 1) % CH;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic next_valid(input int budget, output int gap, output bit ok);
    gap = 0;
    ok  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      gap++;
      if (bus.o_out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic seed_idle(input int ch, input logic [15:0] data);
    bus.i_seed_we   = 1'b1;
    bus.i_seed_ch   = CW'(ch);
    bus.i_seed_data = data;
    tick();
    bus.i_seed_we   = 1'b0;
    mx[ch] = to_signed(data);
  endtask

  task automatic clear_flags();
    bus.i_clear_stuck = 1'b1;
    tick();
    bus.i_clear_stuck = 1'b0;
    mstuck = '0;
  endtask

  // Runs n steps with en high, drops en after the n-th pulse, and collects the
  // in-flight step as well: n+1 outputs, each compared with the model.
  task automatic run_stream(input int mode, input int n);
    int gap, ech, quiet;
    bit ok;
    logic [15:0] edata;
    got_ch.delete();
    got_data.delete();
    gaps.delete();
    bus.i_mode = 2'(mode);
    bus.i_en   = 1'b1;
    for (int k = 0; k <= n; k++) begin
      next_valid(8, gap, ok);
      checks++;
      if (!ok) begin
        $display("FAIL stream_timeout: no out_valid within 8 cycles at output %0d", k);
        failures++;
        bus.i_en = 1'b0;
        break;
      end
      model_step(mode, ech, edata);
      got_ch.push_back(int'(bus.o_out_ch));
      got_data.push_back(bus.o_out_data);
      gaps.push_back(gap);
      checks++;
      if (bus.o_out_ch !== CW'(ech)) begin
        $display("FAIL stream_ch: got %0d expected %0d", bus.o_out_ch, ech);
        failures++;
      end
      checks++;
      if (bus.o_out_data !== edata) begin
        $display("FAIL stream_data ch%0d mode%0d: got %h expected %h", ech, mode, bus.o_out_data, edata);
        failures++;
      end
      checks++;
      if (bus.o_stuck !== mstuck) begin
        $display("FAIL stream_stuck: got %b expected %b", bus.o_stuck, mstuck);
        failures++;
      end
      if (k == n - 1) bus.i_en = 1'b0;
    end
    quiet = 0;
    repeat (6) begin
      tick();
      if (bus.o_out_valid) quiet++;
    end
    checks++;
    if (quiet != 0) begin
      $display("FAIL stream_idle: got %0d pulses after en low, expected 0", quiet);
      failures++;
    end
  endtask

  function automatic int nth_index(input int ch, input int nth);
    int seen = 0;
    foreach (got_ch[i]) begin
      if (got_ch[i] == ch) begin
        if (seen == nth) return i;
        seen++;
      end
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.i_en = 1'b0; bus.i_mode = 2'd0; bus.i_seed_we = 1'b0;
    bus.i_seed_ch = '0; bus.i_seed_data = '0; bus.i_clear_stuck = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
    tick();
    checks++;
    if (bus.o_out_valid !== 1'b0) begin $display("FAIL reset_valid: got %b expected 0", bus.o_out_valid); failures++; end
    checks++;
    if (bus.o_out_ch !== '0) begin $display("FAIL reset_ch: got %0d expected 0", bus.o_out_ch); failures++; end
    checks++;
    if (bus.o_out_data !== 16'h0000) begin $display("FAIL reset_data: got %h expected 0000", bus.o_out_data); failures++; end
    checks++;
    if (bus.o_stuck !== '0) begin $display("FAIL reset_stuck: got %b expected 0000", bus.o_stuck); failures++; end
  endtask

  task automatic test_quadratic_stream();
    run_stream(0, 8);
    checks++;
    if (gaps.size() < 9 || gaps[0] != 3) begin
      $display("FAIL quad_first_latency: got %0d expected 3", (gaps.size() > 0) ? gaps[0] : -1);
      failures++;
    end
    for (int i = 1; i < gaps.size(); i++) begin
      checks++;
      if (gaps[i] != 2) begin $display("FAIL quad_spacing[%0d]: got %0d expected 2", i, gaps[i]); failures++; end
    end
    for (int i = 0; i < 5 && i < got_ch.size(); i++) begin
      checks++;
      if (got_ch[i] != i % CH) begin $display("FAIL quad_order[%0d]: got %0d expected %0d", i, got_ch[i], i % CH); failures++; end
    end
    checks++;
    if (got_data.size() == 0 || got_data[0] !== 16'h843B) begin
      $display("FAIL quad_first_value: got %h expected 843b", (got_data.size() > 0) ? got_data[0] : 16'hxxxx);
      failures++;
    end
  endtask

  task automatic test_seed_saturate();
    int i0, i1;
    seed_idle(0, 16'h7FFF);
    run_stream(0, 8);
    i0 = nth_index(0, 0);
    i1 = nth_index(0, 1);
    checks++;
    if (i0 < 0 || got_data[i0] !== 16'h8003) begin $display("FAIL sat_first: got %h expected 8003", (i0 >= 0) ? got_data[i0] : 16'hxxxx); failures++; end
    checks++;
    if (i1 < 0 || got_data[i1] !== 16'h800B) begin $display("FAIL sat_second: got %h expected 800b", (i1 >= 0) ? got_data[i1] : 16'hxxxx); failures++; end
    checks++;
    if (bus.o_stuck[0] !== 1'b0) begin $display("FAIL sat_stuck0: got %b expected 0", bus.o_stuck[0]); failures++; end
  endtask

  task automatic test_fixed_point_quadratic();
    int idx;
    seed_idle(1, 16'h8000);
    run_stream(0, 4);
    idx = nth_index(1, 0);
    checks++;
    if (idx < 0 || got_data[idx] !== 16'h8155) begin $display("FAIL fixq_value: got %h expected 8155", (idx >= 0) ? got_data[idx] : 16'hxxxx); failures++; end
    checks++;
    if (bus.o_stuck[1] !== 1'b1) begin $display("FAIL fixq_stuck1: got %b expected 1", bus.o_stuck[1]); failures++; end
    clear_flags();
    checks++;
    if (bus.o_stuck !== '0) begin $display("FAIL fixq_clear: got %b expected 0000", bus.o_stuck); failures++; end
  endtask

  task automatic test_tent();
    int idx;
    bus.i_mode = 2'd1;
    seed_idle(2, 16'h2000);
    run_stream(1, 4);
    idx = nth_index(2, 0);
    checks++;
    if (idx < 0 || got_data[idx] !== 16'h3FFF) begin $display("FAIL tent_value: got %h expected 3fff", (idx >= 0) ? got_data[idx] : 16'hxxxx); failures++; end
    seed_idle(2, 16'h8001);
    run_stream(1, 4);
    idx = nth_index(2, 0);
    checks++;
    if (idx < 0 || got_data[idx] !== 16'h8154) begin $display("FAIL tent_fixed: got %h expected 8154", (idx >= 0) ? got_data[idx] : 16'hxxxx); failures++; end
    checks++;
    if (bus.o_stuck[2] !== 1'b1) begin $display("FAIL tent_stuck2: got %b expected 1", bus.o_stuck[2]); failures++; end
  endtask

  task automatic test_cubic();
    int idx;
    seed_idle(3, 16'h4000);
    run_stream(2, 4);
    idx = nth_index(3, 0);
    checks++;
    if (idx < 0 || got_data[idx] !== 16'h8000) begin $display("FAIL cubic_value: got %h expected 8000", (idx >= 0) ? got_data[idx] : 16'hxxxx); failures++; end
    checks++;
    if (gaps.size() < 2 || gaps[0] != 4) begin $display("FAIL cubic_latency: got %0d expected 4", (gaps.size() > 0) ? gaps[0] : -1); failures++; end
    for (int i = 1; i < gaps.size(); i++) begin
      checks++;
      if (gaps[i] != 3) begin $display("FAIL cubic_spacing[%0d]: got %0d expected 3", i, gaps[i]); failures++; end
    end
  endtask

  task automatic test_seed_collision();
    int gap, ech, pulses;
    bit ok;
    logic [15:0] edata, d;
    bus.i_mode = 2'd0;
    bus.i_en   = 1'b1;
    next_valid(8, gap, ok);
    checks++;
    if (!ok) begin $display("FAIL collide_timeout: no out_valid within 8 cycles"); failures++; end
    model_step(0, ech, edata);
    checks++;
    if (bus.o_out_data !== edata) begin $display("FAIL collide_pre: got %h expected %h", bus.o_out_data, edata); failures++; end
    d = 16'($urandom_range(0, 65535));
    bus.i_seed_we   = 1'b1;
    bus.i_seed_ch   = CW'(mptr);
    bus.i_seed_data = d;
    bus.i_en        = 1'b0;
    tick();
    bus.i_seed_we = 1'b0;
    pulses = bus.o_out_valid ? 1 : 0;
    repeat (6) begin
      tick();
      if (bus.o_out_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin $display("FAIL collide_no_valid: got %0d pulses expected 0", pulses); failures++; end
    mx[mptr] = to_signed(d);
    mptr     = (mptr + 1) % CH;
    run_stream(0, 4);
  endtask

  task automatic test_en_drop_wb();
    int gap, ech, pulses;
    bit ok;
    logic [15:0] edata;
    bus.i_mode = 2'd0;
    bus.i_en   = 1'b1;
    next_valid(8, gap, ok);
    model_step(0, ech, edata);
    checks++;
    if (!ok || bus.o_out_data !== edata) begin $display("FAIL wbdrop_first: got %h expected %h", bus.o_out_data, edata); failures++; end
    tick();
    bus.i_en = 1'b0;
    tick();
    model_step(0, ech, edata);
    checks++;
    if (bus.o_out_valid !== 1'b1 || bus.o_out_data !== edata) begin
      $display("FAIL wbdrop_last: got valid=%b data=%h expected valid=1 data=%h", bus.o_out_valid, bus.o_out_data, edata);
      failures++;
    end
    pulses = 0;
    repeat (6) begin
      tick();
      if (bus.o_out_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin $display("FAIL wbdrop_idle: got %0d pulses expected 0", pulses); failures++; end
  endtask

  task automatic test_reset_mid_step();
    int pulses;
    bus.i_mode = 2'd2;
    bus.i_en   = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    bus.i_en = 1'b0;
    checks++;
    if (bus.o_out_valid !== 1'b0 || bus.o_out_ch !== '0 || bus.o_out_data !== 16'h0000 || bus.o_stuck !== '0) begin
      $display("FAIL midrst_outputs: got valid=%b ch=%0d data=%h stuck=%b expected all 0",
               bus.o_out_valid, bus.o_out_ch, bus.o_out_data, bus.o_stuck);
      failures++;
    end
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    pulses = 0;
    repeat (4) begin
      tick();
      if (bus.o_out_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin $display("FAIL midrst_no_valid: got %0d pulses expected 0", pulses); failures++; end
    run_stream(0, 1);
    checks++;
    if (got_data.size() == 0 || got_data[0] !== 16'h843B) begin
      $display("FAIL midrst_seed: got %h expected 843b", (got_data.size() > 0) ? got_data[0] : 16'hxxxx);
      failures++;
    end
  endtask

  task automatic test_random();
    int mode;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < CH; c++) seed_idle(c, 16'($urandom_range(0, 65535)));
      if ($urandom_range(0, 1) == 1) clear_flags();
      mode = int'($urandom_range(0, 3));
      run_stream(mode, int'($urandom_range(3, 10)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_quadratic_stream();
    test_seed_saturate();
    test_fixed_point_quadratic();
    test_tent();
    test_cubic();
    test_seed_collision();
    test_en_drop_wb();
    test_reset_mid_step();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
